bpa_pipe_addsub: RTL and testbench

Parametrised bit-pipelined adder/subtractor, successor to the fixed pipelined block adder. The N-bit datapath is cut into N/M segments of M bits, with one register stage per segment and the carry rippling stage to stage. Adds subtract mode, carry-in, carry-out/overflow flags, valid/ready flow control with full-pipeline stall, and asynchronous reset. Sits in the adder library as the streaming arithmetic core for datapath blocks.

---
 rtl/bpa_pkg.sv | 28 ++
 rtl/bpa_stage.sv | 59 +++++
 rtl/bpa_pipe_addsub.sv | 125 ++++++++++++
 tb/tb_bpa_pipe_addsub.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpa_pkg.sv
// bpa_pkg: shared types, stage-count helper and parameter check for the bit-pipelined adder.
// Rev 1.0
`default_nettype none

`ifndef BPA_PKG_MACROS
`define BPA_PKG_MACROS
`define BPA_CHECK_DIV(n_, m_) \
  if (((n_) % (m_)) != 0) begin : g_bad_div \
    $error("bpa_pipe_addsub: N must be a multiple of M"); \
  end
`endif

package bpa_pkg;

  // Control half of a stage payload; the M-bit sum slice is carried alongside.
  typedef struct packed {
    logic valid;
    logic carry;
    logic carry_msb;
  } stage_ctl_t;

  function automatic int num_stages(input int n, input int m);
    return n / m;
  endfunction

endpackage : bpa_pkg

`default_nettype wire

// File: rtl/bpa_stage.sv
// bpa_stage: one M-bit registered slice adder; data loads only for valid slots.
// Rev 1.0
`default_nettype none

module bpa_stage
  import bpa_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [M-1:0] a_slice_i,
  input  logic [M-1:0] b_slice_i,
  input  logic         cin_i,
  output logic [M-1:0] sum_slice_o,
  output logic         cout_o,
  output logic         cmsb_o,
  output logic         valid_o
);

  logic [M:0]   add_full;
  logic [M-1:0] sum_q, sum_d;
  stage_ctl_t   ctl_q, ctl_d;

  always_comb begin
    add_full = {1'b0, a_slice_i} + {1'b0, b_slice_i} + {{M{1'b0}}, cin_i};
    ctl_d    = ctl_q;
    sum_d    = sum_q;
    if (en_i) begin
      ctl_d.valid = valid_i;
      // Holding data through bubbles keeps the last valid result visible downstream.
      if (valid_i) begin
        sum_d           = add_full[M-1:0];
        ctl_d.carry     = add_full[M];
        ctl_d.carry_msb = a_slice_i[M-1] ^ b_slice_i[M-1] ^ add_full[M-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      sum_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      sum_q <= sum_d;
    end
  end

  assign sum_slice_o = sum_q;
  assign cout_o      = ctl_q.carry;
  assign cmsb_o      = ctl_q.carry_msb;
  assign valid_o     = ctl_q.valid;

endmodule : bpa_stage

`default_nettype wire

// File: rtl/bpa_pipe_addsub.sv
// bpa_pipe_addsub: N-bit adder/subtractor pipelined in N/M carry-rippling stages with global stall.
// Rev 1.0
`default_nettype none

module bpa_pipe_addsub
  import bpa_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int S = num_stages(N, M);

  `BPA_CHECK_DIV(N, M)

  logic         adv;
  logic [N-1:0] b_eff;
  logic [S:0]   slot_v;   // [0] is the incoming beat, [k+1] is stage k
  logic [S:0]   carry;
  logic         last_cmsb;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff     = sub ? ~b : b;
  assign slot_v[0] = in_valid;
  assign carry[0]  = sub ? 1'b1 : cin;

  for (genvar k = 0; k < S; k++) begin : g_slice
    logic [M-1:0] a_stg;
    logic [M-1:0] b_stg;
    logic [M-1:0] sum_stg;
    logic         cmsb;

    if (k == 0) begin : g_direct
      assign a_stg = a[M-1:0];
      assign b_stg = b_eff[M-1:0];
    end else begin : g_skew
      // Tap j sits at pipeline position j, alongside stage j's registers.
      for (genvar j = 0; j < k; j++) begin : g_tap
        logic [M-1:0] a_q, a_d;
        logic [M-1:0] b_q, b_d;
        if (j == 0) begin : g_head
          assign a_d = a[k*M +: M];
          assign b_d = b_eff[k*M +: M];
        end else begin : g_link
          assign a_d = g_tap[j-1].a_q;
          assign b_d = g_tap[j-1].b_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
          end else if (adv && slot_v[j]) begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end
      end
      assign a_stg = g_tap[k-1].a_q;
      assign b_stg = g_tap[k-1].b_q;
    end

    bpa_stage #(.M(M)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (adv),
      .valid_i    (slot_v[k]),
      .a_slice_i  (a_stg),
      .b_slice_i  (b_stg),
      .cin_i      (carry[k]),
      .sum_slice_o(sum_stg),
      .cout_o     (carry[k+1]),
      .cmsb_o     (cmsb),
      .valid_o    (slot_v[k+1])
    );

    if (k == S - 1) begin : g_last
      assign last_cmsb     = cmsb;
      assign sum[k*M +: M] = sum_stg;
    end else begin : g_deskew
      logic cmsb_unused;
      assign cmsb_unused = cmsb;
      // Tap i sits at position k+1+i so the slice lines up with the last stage.
      for (genvar i = 0; i < S - 1 - k; i++) begin : g_tap
        logic [M-1:0] s_q, s_d;
        if (i == 0) begin : g_head
          assign s_d = sum_stg;
        end else begin : g_link
          assign s_d = g_tap[i-1].s_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s_q <= '0;
          end else if (adv && slot_v[k+1+i]) begin
            s_q <= s_d;
          end
        end
      end
      assign sum[k*M +: M] = g_tap[S-2-k].s_q;
    end
  end

  assign out_valid = slot_v[S];
  assign cout      = carry[S];
  assign ovf       = carry[S] ^ last_cmsb;
  assign busy      = |slot_v[S:1];

endmodule : bpa_pipe_addsub

`default_nettype wire

// File: tb/tb_bpa_pipe_addsub.sv
// tb_bpa_pipe_addsub: directed vectors against a transaction-level model (N=16,M=4) plus an N=8,M=8 instance.
// Rev 1.0
`default_nettype none

module tb_bpa_pipe_addsub;

  localparam int S16 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum;

  logic        in_valid8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8, busy8;
  logic [7:0]  sum8;

  int n_vec = 0;
  int n_miss = 0;

  bpa_pipe_addsub #(.N(16), .M(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  bpa_pipe_addsub #(.N(8), .M(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model (16-bit) ----------------
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          pos;
  } ent_t;

  ent_t q[$];
  logic [15:0] last_s = '0;
  logic        last_c = 1'b0, last_v = 1'b0;

  function automatic ent_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    ent_t   e;
    longint ux, uy, sx, sy, r, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      r   = ux - uy;
      sr  = sx - sy;
      e.c = (ux >= uy);
    end else begin
      r   = ux + uy + longint'(ci);
      sr  = sx + sy + longint'(ci);
      e.c = (r >= 65536);
    end
    e.s   = r[15:0];
    e.v   = (sr > 32767) || (sr < -32768);
    e.pos = 0;
    return e;
  endfunction

  function automatic logic front_out();
    return (q.size() > 0) && (q[0].pos == S16 - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_s = '0;
      last_c = 1'b0;
      last_v = 1'b0;
    end else if (!front_out() || out_ready) begin
      if (front_out()) void'(q.pop_front());
      foreach (q[i]) q[i].pos = q[i].pos + 1;
      if (in_valid) q.push_back(model(a, b, cin, sub));
      if (front_out()) begin
        last_s = q[0].s;
        last_c = q[0].c;
        last_v = q[0].v;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, front_out());
    check("in_ready", in_ready, !front_out() || out_ready);
    check("busy", busy, q.size() > 0);
    check("sum", sum, last_s);
    check("cout", cout, last_c);
    check("ovf", ovf, last_v);
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input logic sb);
    logic rdy;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    n_miss++;
    $display("FAIL push_timeout: beat a=%0h never accepted", x);
  endtask

  task automatic expect_latency(input string nm, input int lat, input logic [15:0] s);
    int seen;
    seen = 0;
    for (int i = 1; i <= 12 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = i;
    end
    check({nm, "_latency"}, seen, lat);
    check({nm, "_sum"}, sum, s);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    out_ready = 1'b0;
    // Reset state under random inputs; empty pipe still accepts.
    repeat (2) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
    end
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

    // Single beat
    push(16'h00F8, 16'h0008, 1'b0, 1'b0);
    in_valid = 1'b0;
    expect_latency("single", 4, 16'h0100);
    check("single_cout", cout, 0);
    check("single_ovf", ovf, 0);
    @(posedge clk); #1;

    // Streaming with a mode change on the last beat
    push(16'd3, 16'd1, 1'b0, 1'b0);
    push(16'd5, 16'd2, 1'b0, 1'b0);
    push(16'd100, 16'd100, 1'b0, 1'b0);
    push(16'h0010, 16'h0003, 1'b1, 1'b1);
    in_valid = 1'b0;
    begin
      logic [15:0] exp_s [4];
      exp_s[0] = 16'h0004; exp_s[1] = 16'h0007; exp_s[2] = 16'h00C8; exp_s[3] = 16'h000D;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("stream_valid", out_valid, 1);
        check("stream_sum", sum, exp_s[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Boundaries
    push(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    push(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    push(16'd5, 16'd7, 1'b0, 1'b1);
    push(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    begin
      logic [15:0] exp_s [4];
      logic [3:0]  exp_c, exp_v;
      exp_s[0] = 16'h0000; exp_s[1] = 16'h8000; exp_s[2] = 16'hFFFE; exp_s[3] = 16'hFFFF;
      exp_c = 4'b1001;
      exp_v = 4'b0010;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("bound_sum", sum, exp_s[i]);
        check("bound_cout", cout, exp_c[i]);
        check("bound_ovf", ovf, exp_v[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 3-cycle output stall while 8 beats stream in
    fork
      begin
        for (int k = 0; k < 8; k++)
          push(16'h1111 * 16'(k), 16'h0101, 1'b0, 1'(k % 2));
        in_valid = 1'b0;
      end
      begin
        int seen;
        seen = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        check("bp_first_valid", seen, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_hold_sum", sum, 16'h1010);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Mid-flight asynchronous reset drops in-flight beats
    push(16'h0101, 16'h0202, 1'b0, 1'b0);
    push(16'h0303, 16'h0404, 1'b0, 1'b0);
    push(16'h0505, 16'h0606, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_sum", sum, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    push(16'd2, 16'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    expect_latency("post_rst", 4, 16'h0004);
    @(posedge clk); #1;

    // Single-stage configuration
    a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h11;
    @(negedge clk);
    check("s1_valid", out_valid8, 1);
    check("s1_sum", sum8, 8'h02);
    check("s1_stall_ready", in_ready8, 0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("s1_rst_valid", out_valid8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s1_quiet", out_valid8, 0);
    end
    @(posedge clk); #1;
    a8 = 8'd2; b8 = 8'd2; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("s1_lat_valid", out_valid8, 1);
    check("s1_lat_sum", sum8, 8'h04);
    @(negedge clk);
    check("s1_after_valid", out_valid8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_bpa_pipe_addsub

`default_nettype wire
